// File: rtl/spi_responder_regfile_pkg.sv
// Shared types and command-byte field positions for the SPI responder register file.
package spi_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int NUM_REGS    = 32;
  localparam int ADDR_W      = 5;
  localparam int CMD_ADDR_HI = 7;
  localparam int CMD_ADDR_LO = 3;
  localparam int CMD_WR_BIT  = 1;

endpackage

// File: rtl/spi_responder_regfile_if.sv
// SPI pins plus the local fabric port of the responder register file.
interface spi_responder_regfile_if;
  import spi_resp_pkg::*;

  logic              spi_ss_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [7:0]        status_in;
  logic              fab_we;
  logic [ADDR_W-1:0] fab_addr;
  logic [7:0]        fab_wdata;
  logic [7:0]        fab_rdata;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              irq_n;

  // Device side of the link.
  modport slave (
    input  spi_ss_n, spi_sclk, spi_mosi, status_in, fab_we, fab_addr, fab_wdata,
    output spi_miso, spi_miso_oe, fab_rdata, wr_strobe, wr_addr, wr_data, irq_n
  );

  // SPI master and fabric client side.
  modport master (
    output spi_ss_n, spi_sclk, spi_mosi, status_in, fab_we, fab_addr, fab_wdata,
    input  spi_miso, spi_miso_oe, fab_rdata, wr_strobe, wr_addr, wr_data, irq_n
  );

endinterface

// File: rtl/spi_responder_regfile_sync_edge.sv
// 2-FF synchroniser for an asynchronous input plus one-cycle rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_prev;

  // Two flops for metastability, a third holds last cycle's level for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_responder_regfile.sv
// SPI mode-0 responder fronting a 32 x 8 register file. Command byte selects
// register [7:3] and direction [1]; every following byte of the burst targets
// the same register. A fabric port can write registers and set interrupt flags.
module spi_responder_regfile
  import spi_resp_pkg::*;
#(
  parameter int         IRQ_ADDR       = 25,
  parameter int         IEN_ADDR       = 26,
  parameter logic [7:0] STATUS_DEFAULT = 8'h00
) (
  input logic                     clk,
  input logic                     reset_n,
  spi_responder_regfile_if.slave  bus
);

  localparam logic [ADDR_W-1:0] IRQ_A = IRQ_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] IEN_A = IEN_ADDR[ADDR_W-1:0];

  state_t            r_state, w_state_nx;
  logic [7:0]        r_regs [NUM_REGS];
  logic [6:0]        r_rx_shift;
  logic [6:0]        r_tx_shift;   // bits still to send after the one on MISO
  logic [2:0]        r_bit_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [7:0]        r_next_tx;
  logic              r_byte_done;
  logic              r_miso, r_oe;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_fab_rdata;
  logic              r_irq_n;

  logic       w_ss_rise, w_ss_fall, w_ss_level_unused;
  logic       w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
  logic       w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;
  logic [7:0] w_rx_byte, w_next_tx;
  logic       w_byte_done, w_spi_we;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .i_clk(clk), .i_rst_n(reset_n), .i_async(bus.spi_ss_n),
    .o_sync(w_ss_level_unused), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .i_clk(clk), .i_rst_n(reset_n), .i_async(bus.spi_sclk),
    .o_sync(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .i_clk(clk), .i_rst_n(reset_n), .i_async(bus.spi_mosi),
    .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  assign w_rx_byte   = {r_rx_shift, w_mosi};
  // Deselect wins over a coincident last edge, so an aborted byte never completes.
  assign w_byte_done = (r_state != IDLE) && w_sclk_rise && !w_ss_rise && (r_bit_cnt == 3'd7);
  assign w_spi_we    = w_byte_done && (r_state == DATA) && r_wr;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  // Next state: select starts a command, first byte moves to data, deselect always idles.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_ss_fall) w_state_nx = CMD;
      CMD:     if (w_ss_rise) w_state_nx = IDLE;
               else if (w_byte_done) w_state_nx = DATA;
      DATA:    if (w_ss_rise) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Byte to shift out after the current one: register contents for reads, zero for writes.
  always_comb begin
    w_next_tx = 8'h00;
    if (r_state == CMD) begin
      if (!w_rx_byte[CMD_WR_BIT]) w_next_tx = r_regs[w_rx_byte[CMD_ADDR_HI:CMD_ADDR_LO]];
    end else if (!r_wr) begin
      w_next_tx = r_regs[r_addr];
    end
  end

  // Shift engine: sample MOSI on sclk rise, advance MISO on sclk fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_shift  <= '0;
      r_tx_shift  <= STATUS_DEFAULT[6:0];
      r_bit_cnt   <= '0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_next_tx   <= '0;
      r_byte_done <= 1'b0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_ss_rise) begin
        r_oe        <= 1'b0;
        r_miso      <= 1'b0;
        r_byte_done <= 1'b0;
      end else if (r_state == IDLE) begin
        if (w_ss_fall) begin
          // Status MSB must be on the wire before the first mode-0 rise.
          r_miso      <= bus.status_in[7];
          r_tx_shift  <= bus.status_in[6:0];
          r_bit_cnt   <= '0;
          r_oe        <= 1'b1;
          r_byte_done <= 1'b0;
        end
      end else if (w_sclk_rise) begin
        r_rx_shift <= w_rx_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (w_byte_done) begin
          r_byte_done <= 1'b1;
          r_next_tx   <= w_next_tx;
          if (r_state == CMD) begin
            r_addr <= w_rx_byte[CMD_ADDR_HI:CMD_ADDR_LO];
            r_wr   <= w_rx_byte[CMD_WR_BIT];
          end
          if (w_spi_we) begin
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_addr;
            r_wr_data   <= w_rx_byte;
          end
        end
      end else if (w_sclk_fall) begin
        if (r_byte_done) begin
          r_miso      <= r_next_tx[7];
          r_tx_shift  <= r_next_tx[6:0];
          r_byte_done <= 1'b0;
        end else begin
          r_miso     <= r_tx_shift[6];
          r_tx_shift <= {r_tx_shift[5:0], 1'b0};
        end
      end
    end
  end

  // Register file: SPI beats fabric on the same address, except the IRQ flags
  // where a fabric set survives a simultaneous SPI clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_spi_we && r_addr == ADDR_W'(i)) begin
          if (i == IRQ_ADDR)
            r_regs[i] <= (r_regs[i] & ~w_rx_byte) |
                         ((bus.fab_we && bus.fab_addr == ADDR_W'(i)) ? bus.fab_wdata : 8'h00);
          else
            r_regs[i] <= w_rx_byte;
        end else if (bus.fab_we && bus.fab_addr == ADDR_W'(i)) begin
          r_regs[i] <= (i == IRQ_ADDR) ? (r_regs[i] | bus.fab_wdata) : bus.fab_wdata;
        end
      end
    end
  end

  // Registered fabric read-back and interrupt line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fab_rdata <= '0;
      r_irq_n     <= 1'b1;
    end else begin
      r_fab_rdata <= r_regs[bus.fab_addr];
      r_irq_n     <= ~|(r_regs[IRQ_A] & r_regs[IEN_A]);
    end
  end

  assign bus.spi_miso    = r_miso;
  assign bus.spi_miso_oe = r_oe;
  assign bus.fab_rdata   = r_fab_rdata;
  assign bus.wr_strobe   = r_wr_strobe;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.irq_n       = r_irq_n;

endmodule
